rect_frame_ctrl: RTL and testbench

Frame-synchronous controller for the rectangle overlay layer of the VGA display path. Sensor and UI logic write rectangle coordinates into a staging bank through a valid/ready handshake at any time. The block commits the staged set to the active bank only during vertical blanking, so no frame is drawn with a half-updated layout. For every pixel it reports, one cycle later, whether the pixel lies on an enabled active rectangle and which one wins.

---
 rtl/rect_frame_ctrl_if.sv | 28 ++
 rtl/rect_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rect_frame_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rect_frame_ctrl_if.sv
// Staging-bank write port for rect_frame_ctrl: valid/ready handshake plus
// the rectangle payload and the rejection pulse.
interface rect_frame_ctrl_if #(
  parameter  int unsigned NUM_RECT = 4,
  localparam int unsigned IW       = $clog2(NUM_RECT)
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic [9:0]    wr_x1;
  logic [9:0]    wr_y1;
  logic [9:0]    wr_x2;
  logic [9:0]    wr_y2;
  logic          wr_err;

  modport master (
    output wr_valid, wr_idx, wr_en, wr_x1, wr_y1, wr_x2, wr_y2,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_idx, wr_en, wr_x1, wr_y1, wr_x2, wr_y2,
    output wr_ready, wr_err
  );

endinterface

// File: rtl/rect_frame_ctrl.sv
// Rectangle overlay controller: double-banked rectangle table committed during
// vertical blanking, with a registered per-pixel hit/priority lookup.
module rect_frame_ctrl #(
  parameter  int unsigned NUM_RECT       = 4,
  parameter  int unsigned DISPLAY_WIDTH  = 640,
  parameter  int unsigned DISPLAY_HEIGHT = 480,
  localparam int unsigned IW             = $clog2(NUM_RECT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  vsync_start,
  rect_frame_ctrl_if.slave      wr,
  output logic                  commit_done,
  output logic                  on_any,
  output logic [IW-1:0]         hit_idx
);

  localparam int unsigned CW = 10;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [CW-1:0] x2;
    logic [CW-1:0] y2;
  } rect_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          dirty_q, dirty_d;
  logic          wr_ready_q, wr_ready_d;
  logic          wr_err_q, wr_err_d;
  logic          commit_done_q, commit_done_d;
  logic          on_any_q, on_any_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic          copy_c;

  rect_t stage_q  [NUM_RECT];
  rect_t active_q [NUM_RECT];

  logic  wr_fire_c, wr_bad_c, wr_ok_c;
  rect_t wr_rect_c;

  assign wr.wr_ready  = wr_ready_q;
  assign wr.wr_err    = wr_err_q;
  assign commit_done  = commit_done_q;
  assign on_any       = on_any_q;
  assign hit_idx      = hit_idx_q;

  // Write qualification; a disabled entry is stored verbatim and never rejected.
  always_comb begin
    wr_fire_c = wr.wr_valid && wr_ready_q;
    wr_bad_c  = (32'(wr.wr_idx) >= NUM_RECT) ||
                (wr.wr_en && ((wr.wr_x1 > wr.wr_x2) ||
                              (wr.wr_y1 > wr.wr_y2) ||
                              (32'(wr.wr_x2) >= DISPLAY_WIDTH) ||
                              (32'(wr.wr_y2) >= DISPLAY_HEIGHT)));
    wr_ok_c   = wr_fire_c && !wr_bad_c;
    wr_rect_c = '{en: wr.wr_en, x1: wr.wr_x1, y1: wr.wr_y1,
                  x2: wr.wr_x2, y2: wr.wr_y2};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dirty_d       = dirty_q || wr_ok_c;
    wr_ready_d    = wr_ready_q;
    wr_err_d      = wr_fire_c && wr_bad_c;
    commit_done_d = 1'b0;
    copy_c        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_ready_d = 1'b1;
        // dirty_d already folds in a write landing on this same edge
        if (vsync_start && dirty_d) begin
          state_d    = ST_COMMIT;
          cnt_d      = '0;
          dirty_d    = 1'b0;
          wr_ready_d = 1'b0;
        end
      end
      ST_COMMIT: begin
        copy_c     = 1'b1;
        wr_ready_d = 1'b0;
        cnt_d      = cnt_q + IW'(1);
        if (32'(cnt_q) == NUM_RECT - 1) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          wr_ready_d    = 1'b1;
          commit_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wr_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dirty_q       <= 1'b0;
      wr_ready_q    <= 1'b1;
      wr_err_q      <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dirty_q       <= dirty_d;
      wr_ready_q    <= wr_ready_d;
      wr_err_q      <= wr_err_d;
      commit_done_q <= commit_done_d;
    end
  end

  // Staging and active banks; reset clears both, discarding any partial commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_RECT); i++) begin
        stage_q[i]  <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_ok_c) begin
        stage_q[wr.wr_idx] <= wr_rect_c;
      end
      if (copy_c) begin
        active_q[cnt_q] <= stage_q[cnt_q];
      end
    end
  end

  // Priority hit search: lowest matching index wins.
  always_comb begin
    logic found;
    found     = 1'b0;
    hit_idx_d = '0;
    for (int i = 0; i < int'(NUM_RECT); i++) begin
      if (!found && active_q[i].en &&
          (x >= active_q[i].x1) && (x <= active_q[i].x2) &&
          (y >= active_q[i].y1) && (y <= active_q[i].y2)) begin
        found     = 1'b1;
        hit_idx_d = IW'(i);
      end
    end
    on_any_d = video_on && found;
    if (!on_any_d) begin
      hit_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_any_q  <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      on_any_q  <= on_any_d;
      hit_idx_q <= hit_idx_d;
    end
  end

endmodule

// File: tb/tb_rect_frame_ctrl.sv
// Directed bench for rect_frame_ctrl: reset, frame sweep, commit timing,
// priority, invalid writes, same-edge write/vsync and reset mid-commit.
module tb_rect_frame_ctrl;

  localparam int unsigned NUM_RECT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       vsync_start;
  logic       commit_done;
  logic       on_any;
  logic [1:0] hit_idx;

  int n_pass  = 0;
  int n_total = 0;

  rect_frame_ctrl_if #(.NUM_RECT(NUM_RECT)) wr_bus ();

  rect_frame_ctrl #(
    .NUM_RECT      (NUM_RECT),
    .DISPLAY_WIDTH (640),
    .DISPLAY_HEIGHT(480)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .vsync_start(vsync_start),
    .wr         (wr_bus),
    .commit_done(commit_done),
    .on_any     (on_any),
    .hit_idx    (hit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input int xv, input int yv, input logic von,
                     input logic exp_on, input int exp_idx);
    x        = 10'(xv);
    y        = 10'(yv);
    video_on = von;
    tick();
    check({tag, "_on"},  32'(on_any),  32'(exp_on));
    check({tag, "_idx"}, 32'(hit_idx), 32'(exp_idx));
  endtask

  task automatic set_wr(input int idx, input logic en, input int x1, input int y1,
                        input int x2, input int y2);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_idx   = 2'(idx);
    wr_bus.wr_en    = en;
    wr_bus.wr_x1    = 10'(x1);
    wr_bus.wr_y1    = 10'(y1);
    wr_bus.wr_x2    = 10'(x2);
    wr_bus.wr_y2    = 10'(y2);
  endtask

  task automatic write_entry(input string tag, input int idx, input logic en,
                             input int x1, input int y1, input int x2, input int y2,
                             input logic exp_err);
    set_wr(idx, en, x1, y1, x2, y2);
    tick();
    wr_bus.wr_valid = 1'b0;
    check({tag, "_err"}, 32'(wr_bus.wr_err), 32'(exp_err));
  endtask

  // Pulses vsync (optionally again two edges later) and observes 8 cycles.
  task automatic run_commit(input logic repulse, output int low, output int done,
                            output logic err0);
    vsync_start = 1'b1;
    tick();
    vsync_start     = 1'b0;
    wr_bus.wr_valid = 1'b0;
    err0 = wr_bus.wr_err;
    low  = (wr_bus.wr_ready == 1'b0) ? 1 : 0;
    done = (commit_done == 1'b1) ? 1 : 0;
    for (int k = 1; k < 8; k++) begin
      if (repulse && k == 2) vsync_start = 1'b1;
      tick();
      vsync_start = 1'b0;
      low  += (wr_bus.wr_ready == 1'b0) ? 1 : 0;
      done += (commit_done == 1'b1) ? 1 : 0;
    end
  endtask

  initial begin
    int   hits;
    int   bad_idx;
    int   not_ready;
    int   low;
    int   done;
    logic err0;

    reset_n         = 1'b0;
    x               = '0;
    y               = '0;
    video_on        = 1'b0;
    vsync_start     = 1'b0;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_idx   = '0;
    wr_bus.wr_en    = 1'b0;
    wr_bus.wr_x1    = '0;
    wr_bus.wr_y1    = '0;
    wr_bus.wr_x2    = '0;
    wr_bus.wr_y2    = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready",  32'(wr_bus.wr_ready), 32'd1);
    check("rst_err",    32'(wr_bus.wr_err),   32'd0);
    check("rst_done",   32'(commit_done),     32'd0);
    check("rst_on",     32'(on_any),          32'd0);
    check("rst_idx",    32'(hit_idx),         32'd0);
    reset_n = 1'b1;
    tick();

    // Coarse full-frame sweep with an empty active bank
    hits = 0; bad_idx = 0; not_ready = 0;
    for (int yy = 0; yy < 480; yy += 8) begin
      for (int xx = 0; xx < 640; xx += 8) begin
        x = 10'(xx + (yy % 8 == 0 ? 7 : 0) * ((xx == 632) ? 1 : 0));
        y = 10'(yy);
        video_on = 1'b1;
        tick();
        hits      += on_any ? 1 : 0;
        bad_idx   += (hit_idx != 2'd0) ? 1 : 0;
        not_ready += wr_bus.wr_ready ? 0 : 1;
      end
    end
    check("sweep_hits",  32'(hits),      32'd0);
    check("sweep_idx",   32'(bad_idx),   32'd0);
    check("sweep_ready", 32'(not_ready), 32'd0);

    // Single rectangle, commit timing and edges
    write_entry("w1", 1, 1'b1, 320, 100, 325, 105, 1'b0);
    run_commit(1'b0, low, done, err0);
    check("c1_low",  32'(low),  32'd4);
    check("c1_done", 32'(done), 32'd1);
    pix("p_tl",     320, 100, 1'b1, 1'b1, 1);
    pix("p_br",     325, 105, 1'b1, 1'b1, 1);
    pix("p_mid",    322, 103, 1'b1, 1'b1, 1);
    pix("p_left",   319, 100, 1'b1, 1'b0, 0);
    pix("p_right",  326, 105, 1'b1, 1'b0, 0);
    pix("p_below",  320, 106, 1'b1, 1'b0, 0);
    pix("p_above",  320,  99, 1'b1, 1'b0, 0);

    // Overlap priority
    write_entry("w0", 0, 1'b1, 0, 0,  9,  9, 1'b0);
    write_entry("w2", 2, 1'b1, 5, 5, 20, 20, 1'b0);
    run_commit(1'b0, low, done, err0);
    check("c2_low",  32'(low),  32'd4);
    check("c2_done", 32'(done), 32'd1);
    pix("ov_7",      7,  7, 1'b1, 1'b1, 0);
    pix("ov_15",    15, 15, 1'b1, 1'b1, 2);
    pix("ov_7_off",  7,  7, 1'b0, 1'b0, 0);
    pix("ov_r1",   322, 103, 1'b1, 1'b1, 1);

    // Invalid writes: rejected and they leave dirty clear
    write_entry("bad_x", 1, 1'b1, 50, 0, 40, 5, 1'b1);
    tick();
    check("bad_x_pulse", 32'(wr_bus.wr_err), 32'd0);
    write_entry("bad_y", 3, 1'b1, 0, 0, 10, 480, 1'b1);
    run_commit(1'b0, low, done, err0);
    check("c3_low",  32'(low),  32'd0);
    check("c3_done", 32'(done), 32'd0);

    // Disabled entry with out-of-range coordinates is accepted
    write_entry("dis3", 3, 1'b0, 600, 470, 700, 490, 1'b0);
    run_commit(1'b0, low, done, err0);
    check("c4_low",  32'(low),  32'd4);
    check("c4_done", 32'(done), 32'd1);
    pix("r1_kept", 322, 103, 1'b1, 1'b1, 1);
    pix("dis3_px", 650, 475, 1'b1, 1'b0, 0);

    // Write on the vsync edge, second vsync during commit ignored
    set_wr(3, 1'b1, 100, 200, 110, 210);
    run_commit(1'b1, low, done, err0);
    check("c5_err",  32'(err0), 32'd0);
    check("c5_low",  32'(low),  32'd4);
    check("c5_done", 32'(done), 32'd1);
    pix("r3_in",  105, 205, 1'b1, 1'b1, 3);
    pix("r3_out", 111, 205, 1'b1, 1'b0, 0);

    // Reset asserted at E2 of a commit
    write_entry("w2b", 2, 1'b1, 5, 5, 20, 20, 1'b0);
    x = 10'd7; y = 10'd7; video_on = 1'b1;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    check("mr_ready_lo", 32'(wr_bus.wr_ready), 32'd0);
    check("mr_on_pre",   32'(on_any),          32'd1);
    tick();
    @(posedge clk);
    reset_n = 1'b0;
    #1;
    check("mr_ready", 32'(wr_bus.wr_ready), 32'd1);
    check("mr_done",  32'(commit_done),     32'd0);
    check("mr_err",   32'(wr_bus.wr_err),   32'd0);
    check("mr_on",    32'(on_any),          32'd0);
    tick();
    reset_n = 1'b1;
    pix("mr_p7",    7,   7,  1'b1, 1'b0, 0);
    pix("mr_p15",  15,  15,  1'b1, 1'b0, 0);
    pix("mr_r1",  322, 103,  1'b1, 1'b0, 0);
    pix("mr_r3",  105, 205,  1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
